// File: rtl/vga_square_collision_ctrl.sv
// Per-frame collision scheduler: snapshots square origins at the start of blanking, tests one pair per clock,
// then issues a single step strobe with per-square X/Y direction-flip vectors so every mover updates together.
module vga_square_collision_ctrl #(
  parameter int NUM_SQ  = 4,
  parameter int SQ_SIZE = 100,
  parameter int V_SIZE  = 480,
  parameter int FRAMES  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [9:0]            sx,
  input  logic [9:0]            sy,
  input  logic [10*NUM_SQ-1:0]  pos_x_flat,
  input  logic [10*NUM_SQ-1:0]  pos_y_flat,
  output logic                  busy,
  output logic                  step,
  output logic [NUM_SQ-1:0]     flip_x,
  output logic [NUM_SQ-1:0]     flip_y,
  output logic [5:0]            hits
);

  typedef enum logic [1:0] {IDLE, SNAP, SCAN, ISSUE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        fcnt_q, fcnt_d;
  logic [2:0]        i_q, i_d, j_q, j_d;
  logic [9:0]        px_q [NUM_SQ];
  logic [9:0]        px_d [NUM_SQ];
  logic [9:0]        py_q [NUM_SQ];
  logic [9:0]        py_d [NUM_SQ];
  logic [NUM_SQ-1:0] fx_q, fx_d, fy_q, fy_d;
  logic [5:0]        cnt_q, cnt_d, hits_q, hits_d;

  logic       new_frame, start, last_pair, overlap;
  logic [9:0] xi, xj, yi, yj, dx, dy;

  assign new_frame = (sy == 10'(V_SIZE)) && (sx == 10'd0);
  assign start     = new_frame && enable && (fcnt_q == 4'd0) && (state_q == IDLE);
  assign last_pair = (i_q == 3'(NUM_SQ-2)) && (j_q == 3'(NUM_SQ-1));

  // Pair operand select from the snapshot, then larger-minus-smaller distances.
  always_comb begin
    xi = '0;
    xj = '0;
    yi = '0;
    yj = '0;
    for (int k = 0; k < NUM_SQ; k++) begin
      if (3'(k) == i_q) begin
        xi = px_q[k];
        yi = py_q[k];
      end
      if (3'(k) == j_q) begin
        xj = px_q[k];
        yj = py_q[k];
      end
    end
    dx      = (xi >= xj) ? (xi - xj) : (xj - xi);
    dy      = (yj >= yi) ? (yj - yi) : (yi - yj);
    overlap = (dx < 10'(SQ_SIZE)) && (dy < 10'(SQ_SIZE));
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    i_d     = i_q;
    j_d     = j_q;
    px_d    = px_q;
    py_d    = py_q;
    fx_d    = fx_q;
    fy_d    = fy_q;
    cnt_d   = cnt_q;
    hits_d  = hits_q;

    // The divider counts every enabled frame, even ones that arrive mid-scan.
    if (new_frame && enable) begin
      fcnt_d = (fcnt_q == 4'(FRAMES-1)) ? 4'd0 : fcnt_q + 4'd1;
    end

    case (state_q)
      IDLE: begin
        if (start) state_d = SNAP;
      end
      SNAP: begin
        for (int k = 0; k < NUM_SQ; k++) begin
          px_d[k] = pos_x_flat[10*k +: 10];
          py_d[k] = pos_y_flat[10*k +: 10];
        end
        fx_d    = '0;
        fy_d    = '0;
        cnt_d   = '0;
        i_d     = 3'd0;
        j_d     = 3'd1;
        state_d = SCAN;
      end
      SCAN: begin
        if (overlap) begin
          cnt_d = (cnt_q == 6'd63) ? 6'd63 : cnt_q + 6'd1;
          for (int k = 0; k < NUM_SQ; k++) begin
            if ((3'(k) == i_q) || (3'(k) == j_q)) begin
              if (dx >= dy) fx_d[k] = 1'b1;
              else          fy_d[k] = 1'b1;
            end
          end
        end
        if (last_pair) begin
          hits_d  = cnt_d;
          state_d = ISSUE;
        end else if (j_q == 3'(NUM_SQ-1)) begin
          i_d = i_q + 3'd1;
          j_d = i_q + 3'd2;
        end else begin
          j_d = j_q + 3'd1;
        end
      end
      ISSUE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
      i_q     <= 3'd0;
      j_q     <= 3'd1;
      fx_q    <= '0;
      fy_q    <= '0;
      cnt_q   <= '0;
      hits_q  <= '0;
      for (int k = 0; k < NUM_SQ; k++) begin
        px_q[k] <= '0;
        py_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      i_q     <= i_d;
      j_q     <= j_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
      cnt_q   <= cnt_d;
      hits_q  <= hits_d;
      px_q    <= px_d;
      py_q    <= py_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign step   = (state_q == ISSUE);
  assign flip_x = step ? fx_q : '0;
  assign flip_y = step ? fy_q : '0;
  assign hits   = hits_q;

endmodule

// File: doc/vga_square_collision_ctrl.md
Name: vga_square_collision_ctrl

Overview:
- Per-frame scheduler for a group of NUM_SQ bouncing squares sharing one 640x480 playfield.
- At the start of vertical blanking it snapshots every square's origin and walks all unordered pairs, one pair per clock, testing for axis-aligned overlap.
- It then issues one step strobe together with per-square direction-flip vectors, so all squares update position in the same cycle.
- Sits between the VGA timing generator (sx/sy) and the bank of square movers, which consume step/flip_x/flip_y.

Parameters:
NUM_SQ, 4, number of squares (2..8).
SQ_SIZE, 100, square edge length in pixels.
V_SIZE, 480, first blanking line; new_frame = (sy == V_SIZE) && (sx == 0).
FRAMES, 1, squares are stepped once every FRAMES frames (1..15).

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous active-high reset
enable  in  1  when 0, new frames are ignored and the FSM stays in IDLE
sx  in  10  current pixel column
sy  in  10  current pixel line
pos_x_flat  in  10*NUM_SQ  square origins X; square k at bits [10k+9:10k]
pos_y_flat  in  10*NUM_SQ  square origins Y, same packing
busy  out  1  high from SNAP through ISSUE
step  out  1  one-cycle pulse; squares advance one move
flip_x  out  NUM_SQ  valid only while step=1; bit k=1 reverses square k's X direction
flip_y  out  NUM_SQ  valid only while step=1; same for Y
hits  out  6  number of colliding pairs found in the last completed scan; held until the next ISSUE

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, step=0, flip_x=0, flip_y=0, hits=0, frame counter=0, pair indices i=0, j=1.
- Frame divider: on each new_frame cycle with enable=1, fcnt <= (fcnt==FRAMES-1) ? 0 : fcnt+1. A scan starts only when new_frame && enable && fcnt==0 && state==IDLE.
- States:
  - IDLE: wait for the start condition, then go to SNAP.
  - SNAP, 1 cycle: register all positions into a local array; clear the flip accumulators and the hit counter; set i=0, j=1; go to SCAN.
  - SCAN, one pair per cycle in order (0,1),(0,2)..(0,N-1),(1,2)..(N-2,N-1), i.e. P=N(N-1)/2 cycles:
    - dx=|xi-xj| and dy=|yj-yi|, computed as 10-bit unsigned differences with the larger operand first.
    - Overlap when dx<SQ_SIZE and dy<SQ_SIZE. Touching edges (difference == SQ_SIZE) do not overlap.
    - On overlap: hits++. If dx>=dy, set accumulator bits fx[i] and fx[j]; otherwise set fy[i] and fy[j]. Bits are OR-accumulated, so a square hit on the same axis by several partners flips once.
    - After the last pair, go to ISSUE.
  - ISSUE, 1 cycle: step=1, flip_x=fx, flip_y=fy, hits register loaded; next state IDLE.
- Latency: start condition in cycle T gives SNAP in T+1, SCAN in T+2..T+1+P, ISSUE in T+2+P. For NUM_SQ=4 this is step at T+8, far inside blanking.
- busy=1 in SNAP, SCAN and ISSUE.
- flip_x and flip_y are 0 whenever step=0.
- Positions are sampled only in SNAP; input changes during SCAN have no effect.
- new_frame while busy: ignored for scan start; fcnt still advances.
- enable dropped mid-scan: the scan completes and ISSUE still fires. enable gates only starts.
- rst mid-scan: immediate return to IDLE; no step is issued for that frame.
- NUM_SQ=1 is unsupported (P=0). hits saturates at 63.

Test Plan:
- NUM_SQ=2, positions (0,0) and (300,300), new_frame pulse → step at T+3 (P=1); flip_x=00, flip_y=00, hits=0.
- NUM_SQ=2, (100,100) and (180,130): dx=80 >= dy=30 → step with flip_x=11, flip_y=00, hits=1.
- NUM_SQ=2, (100,100) and (130,190): dx=30 < dy=90 → flip_x=00, flip_y=11, hits=1. With (100,100) and (200,100), dx=100 is touching only → no flips.
- NUM_SQ=4, squares 0, 1 and 2 mutually X-overlapping at (0,0), (50,10) and (90,20), square 3 at (500,300) → step at T+8; flip_x=0111, flip_y=0000, hits=3; busy high T+1..T+8.
- FRAMES=3, enable=1, 6 consecutive new_frame pulses → exactly 2 steps, on pulses 1 and 4. Same run with enable=0 → no step, busy stays 0.
- Assert rst during SCAN (cycle T+4, NUM_SQ=4) → busy=0 next edge, no step for that frame; the next frame scans normally.
